// File: rtl/bubble_sort_seq_ctrl_pkg.sv
// Shared types and helpers for the sequential bubble sorter: controller states,
// pass-counter width and packed-element slicing.
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pass counter must hold DIM-1; never narrower than one bit.
  function automatic int calc_cw(input int dim);
    return (dim <= 2) ? 1 : $clog2(dim);
  endfunction

  function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/bubble_sort_seq_ctrl_if.sv
// Producer/consumer handshake bundle plus status for the sequential bubble sorter.
interface bubble_sort_seq_ctrl_if #(
  parameter int DIM   = 10,
  parameter int WIDTH = 8,
  parameter int CW    = bubble_sort_pkg::calc_cw(DIM)
);
  import bubble_sort_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DIM*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIM*WIDTH-1:0] out_data;
  logic                 busy;
  logic [CW-1:0]        passes_used;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, passes_used
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, passes_used
  );

endinterface

// File: rtl/bubble_sort_seq_ctrl_pass.sv
// One combinational bubble pass over a packed array: compare-exchange pairs
// (j,j+1) for j=0..DIM-1-pass, strict greater-than so equal elements stay put.
module bubble_pass_flag
  import bubble_sort_pkg::*;
#(
  parameter int DIM   = 10,
  parameter int WIDTH = 8,
  parameter int CW    = calc_cw(DIM)
) (
  input  logic [DIM*WIDTH-1:0] arr,
  input  logic [CW-1:0]        pass,
  output logic [DIM*WIDTH-1:0] arr_next,
  output logic                 swapped
);

  localparam int unsigned N = unsigned'(DIM);
  localparam int unsigned W = unsigned'(WIDTH);

  logic [WIDTH-1:0] a [DIM];
  logic [WIDTH-1:0] t;

  always_comb begin
    t        = '0;
    swapped  = 1'b0;
    arr_next = '0;
    for (int unsigned k = 0; k < N; k++) begin
      a[k] = arr[elem_lsb(k, W) +: WIDTH];
    end
    // Exchanges chain within the pass, so the largest remaining element bubbles up.
    for (int unsigned j = 0; j + 1 < N; j++) begin
      if ((j + 32'(pass) < N) && (a[j] > a[j+1])) begin
        t      = a[j];
        a[j]   = a[j+1];
        a[j+1] = t;
        swapped = 1'b1;
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      arr_next[elem_lsb(k, W) +: WIDTH] = a[k];
    end
  end

endmodule

// File: rtl/bubble_sort_seq_ctrl.sv
// Multi-cycle bubble sorter: accepts a packed array, runs one pass per clock on a
// registered copy, stops early on a swap-free pass and presents the sorted array.
module bubble_sort_seq_ctrl
  import bubble_sort_pkg::*;
#(
  parameter int DIM   = 10,
  parameter int WIDTH = 8,
  parameter int CW    = calc_cw(DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  bubble_sort_seq_ctrl_if.slave bus
);

  localparam int N = DIM * WIDTH;
  localparam logic [CW-1:0] LAST_PASS = CW'(DIM - 1);

  if (DIM < 2) begin : g_dim_check
    $error("bubble_sort_seq_ctrl: DIM must be at least 2");
  end

  state_t        state_q, state_d;
  logic [N-1:0]  arr_q, arr_d, pass_arr;
  logic [CW-1:0] pass_q, pass_d;
  logic [CW-1:0] pu_q, pu_d;
  logic          swapped;

  bubble_pass_flag #(
    .DIM   (DIM),
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_pass (
    .arr      (arr_q),
    .pass     (pass_q),
    .arr_next (pass_arr),
    .swapped  (swapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      arr_q   <= '0;
      pass_q  <= '0;
      pu_q    <= '0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      pass_q  <= pass_d;
      pu_q    <= pu_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    arr_d         = arr_q;
    pass_d        = pass_q;
    pu_d          = pu_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          arr_d   = bus.in_data;
          pass_d  = CW'(1);
          pu_d    = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        bus.busy = 1'b1;
        arr_d    = pass_arr;
        pu_d     = pass_q;
        if (!swapped || (pass_q == LAST_PASS)) begin
          state_d = DONE;
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data    = arr_q;
  assign bus.passes_used = pu_q;

endmodule

// File: tb/tb_bubble_sort_seq_ctrl.sv
// Self-checking bench for bubble_sort_seq_ctrl at DIM=4, WIDTH=8: directed table,
// backpressure and reset corner cases, and a randomized stream against a sort model.
module tb_bubble_sort_seq_ctrl;
  import bubble_sort_pkg::*;

  localparam int DIM   = 4;
  localparam int WIDTH = 8;
  localparam int CW    = calc_cw(DIM);
  localparam int NSTREAM = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bubble_sort_seq_ctrl_if #(.DIM(DIM), .WIDTH(WIDTH), .CW(CW)) bus ();

  bubble_sort_seq_ctrl #(.DIM(DIM), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    int          passes;
  } vec_t;

  vec_t vecs [6];
  logic [31:0] sent_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Reference: passes = 1 + max count of strictly larger elements preceding any
  // element (each swapping pass moves such an element left by one), capped at DIM-1.
  function automatic void ref_model(input logic [31:0] din, output logic [31:0] dout,
                                    output int pu);
    int vals [$];
    int worst;
    int cnt;
    worst = 0;
    for (int i = 0; i < DIM; i++) vals.push_back(int'(din[i*WIDTH +: WIDTH]));
    for (int i = 0; i < DIM; i++) begin
      cnt = 0;
      for (int j = 0; j < i; j++) if (vals[j] > vals[i]) cnt++;
      if (cnt > worst) worst = cnt;
    end
    pu = worst + 1;
    if (pu > DIM - 1) pu = DIM - 1;
    vals.sort();
    dout = '0;
    for (int i = 0; i < DIM; i++) dout[i*WIDTH +: WIDTH] = 8'(vals[i]);
  endfunction

  initial begin
    int lat, busy_cnt, seen, got, n_acc;
    logic [31:0] d;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_passes", 32'(bus.passes_used), 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{pack4(4, 3, 2, 1),     pack4(1, 2, 3, 4),     3};
    vecs[1] = '{pack4(1, 2, 3, 4),     pack4(1, 2, 3, 4),     1};
    vecs[2] = '{pack4(5, 5, 5, 5),     pack4(5, 5, 5, 5),     1};
    vecs[3] = '{pack4(9, 0, 9, 0),     pack4(0, 0, 9, 9),     3};
    vecs[4] = '{pack4(200, 7, 255, 0), pack4(0, 7, 200, 255), 3};
    vecs[5] = '{pack4(2, 1, 3, 4),     pack4(1, 2, 3, 4),     2};

    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("vec_in_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].din;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!bus.out_valid && lat < 16) begin
        if (bus.busy) busy_cnt++;
        tick();
        lat++;
      end
      check("vec_latency", 32'(lat), 32'(vecs[i].passes));
      check("vec_busy_cycles", 32'(busy_cnt), 32'(vecs[i].passes));
      check("vec_data", bus.out_data, vecs[i].dout);
      check("vec_passes", 32'(bus.passes_used), 32'(vecs[i].passes));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("vec_back_idle", 32'(bus.in_ready), 1);
      check("vec_valid_drop", 32'(bus.out_valid), 0);
    end

    // Backpressure: result held while out_ready stays low, inputs ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = pack4(200, 7, 255, 0);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 16) begin
      tick();
      lat++;
    end
    check("bp_latency", 32'(lat), 3);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c % 2) == 0;
      bus.in_data  = $urandom;
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_out_data", bus.out_data, pack4(0, 7, 200, 255));
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_busy", 32'(bus.busy), 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    check("bp_still_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_idle", 32'(bus.in_ready), 1);
    check("bp_release_valid", 32'(bus.out_valid), 0);
    tick();
    check("bp_no_ghost_accept", 32'(bus.in_ready), 1);

    // Reset on the second SORT cycle discards the job.
    bus.in_valid = 1'b1;
    bus.in_data  = pack4(4, 3, 2, 1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mid_busy_before_rst", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_passes", 32'(bus.passes_used), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_data", bus.out_data, 0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    bus.out_ready = 1'b0;
    check("mid_rst_no_output", 32'(seen), 0);

    // Random stream with independent producer and consumer.
    got = 0;
    n_acc = 0;
    fork
      begin : producer
        logic [31:0] din;
        bit hs;
        int guard;
        for (int n = 0; n < NSTREAM; n++) begin
          for (int k = 0; k < DIM; k++)
            din[k*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                               : 8'($urandom_range(0, 255));
          repeat ($urandom_range(0, 2)) tick();
          bus.in_valid = 1'b1;
          bus.in_data  = din;
          sent_q.push_back(din);
          hs = 1'b0;
          guard = 0;
          while (!hs && guard < 200) begin
            hs = bus.in_ready;
            tick();
            guard++;
          end
          bus.in_valid = 1'b0;
          if (!hs) break;
          n_acc++;
        end
      end
      begin : consumer
        logic rdy, v;
        logic [31:0] dat, exp_d, din;
        logic [CW-1:0] pu;
        int exp_pu;
        int cyc;
        cyc = 0;
        while (got < NSTREAM && cyc < 30000) begin
          rdy = ($urandom_range(0, 2) != 0);
          bus.out_ready = rdy;
          v   = bus.out_valid;
          dat = bus.out_data;
          pu  = bus.passes_used;
          tick();
          cyc++;
          if (v && rdy) begin
            din = (sent_q.size() > 0) ? sent_q.pop_front() : 32'hx;
            ref_model(din, exp_d, exp_pu);
            check("stream_data", dat, exp_d);
            check("stream_passes", 32'(pu), 32'(exp_pu));
            got++;
          end
        end
        bus.out_ready = 1'b0;
      end
    join
    check("stream_accepted", 32'(n_acc), 32'(NSTREAM));
    check("stream_received", 32'(got), 32'(NSTREAM));
    check("stream_leftover", 32'(sent_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
